// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Front-end sequencing controller for the 5-stage core. Decides, each
//   cycle, whether the PC advances, whether IF_ID loads, is flushed to a NOP
//   or holds, and whether ID_EX receives a bubble. Inputs considered:
//   load-use hazards in ID, taken branches resolved in EX, and instruction
//   memory readiness.
//
// Parameters
//   FLUSH_SLOTS : wrong-path cycles flushed per taken branch (1..7),
//                 counting the resolve cycle itself.
//   CNT_W       : width of the performance counters.
//
// Ports
//   clk, reset (async, active-low)
//   id_rs, id_rt, id_uses_rt     : source fields of the instruction in ID
//   ex_mem_read, ex_rt           : load in EX and its destination register
//   branch_taken                 : branch in EX resolved taken this cycle
//   imem_ready                   : instruction memory returns a word
//   imem_req, pc_we, if_id_we, if_id_flush, id_ex_bubble : pipeline controls
//   state                        : current FSM state (IDLE/RUN/WAIT/FLUSH)
//   stall_cnt, flush_cnt         : performance counters
//
// Configuration
//   PIPE_HAZARD_CTRL_PERF_EN : when defined, stall_cnt/flush_cnt count
//   load-use stall cycles and accepted taken branches (saturating); when
//   undefined both are tied to zero.

module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_SLOTS = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [2:0] SLOT_INIT = 3'(FLUSH_SLOTS - 1);

  state_t     state_q, state_nxt;
  logic [2:0] slot_q, slot_nxt;
  logic       hazard;
  logic       take_branch;
  logic       take_stall;

  // Register 0 is hardwired, so a load targeting it can never feed ID.
  assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_nxt;
      slot_q  <= slot_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    slot_nxt     = slot_q;
    imem_req     = 1'b0;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b1;
    take_branch  = 1'b0;
    take_stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_nxt = RUN;
      end
      RUN, WAIT: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          // Branch beats a simultaneous hazard: the stalled ID instruction
          // is wrong-path anyway. Any outstanding fetch is abandoned.
          take_branch  = 1'b1;
          pc_we        = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (FLUSH_SLOTS > 1) begin
            state_nxt = FLUSH;
            slot_nxt  = SLOT_INIT;
          end else begin
            state_nxt = RUN;
          end
        end else if (hazard) begin
          take_stall   = 1'b1;
          if_id_flush  = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (!imem_ready) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b0;
          state_nxt    = WAIT;
        end else begin
          pc_we        = 1'b1;
          if_id_we     = 1'b1;
          if_id_flush  = 1'b0;
          id_ex_bubble = 1'b0;
          state_nxt    = RUN;
        end
      end
      FLUSH: begin
        imem_req = 1'b1;
        slot_nxt = slot_q - 3'd1;
        // Leave when the decremented count reaches zero.
        if (slot_q <= 3'd1) begin
          state_nxt = RUN;
          slot_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (take_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (take_branch && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  logic unused_perf;
  assign unused_perf = take_stall ^ take_branch;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl with FLUSH_SLOTS=3. A
//   behavioural model tracks "in reset/idle", "flush cycles left" and
//   "waiting on fetch" plus event counts; directed scenarios are followed by
//   randomized traffic including asynchronous resets.

module tb_pipe_hazard_ctrl;

  localparam int unsigned FS = 3;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_mem_read, branch_taken, imem_ready;
  logic          imem_req, pc_we, if_id_we, if_id_flush, id_ex_bubble;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_SLOTS(FS), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .imem_ready(imem_ready),
    .imem_req(imem_req), .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  bit m_idle;
  int m_flush_left;
  bit m_wait;
  int m_stalls, m_flushes;
  localparam int MAXC = (1 << CW) - 1;

  function automatic bit m_hazard();
    return ex_mem_read && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  task automatic model_reset();
    m_idle = 1; m_flush_left = 0; m_wait = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_step();
    if (!reset) model_reset();
    else if (m_idle) m_idle = 0;
    else if (m_flush_left > 0) m_flush_left--;
    else if (branch_taken) begin
      m_flush_left = FS - 1;
      m_wait = 0;
      if (m_flushes < MAXC) m_flushes++;
    end else if (m_hazard()) begin
      if (m_stalls < MAXC) m_stalls++;
    end else m_wait = !imem_ready;
  endtask

  task automatic check_all();
    int es;
    bit e_req, e_pc, e_fl, e_bub, we_known, e_we;
    we_known = 1; e_we = 0;
    if (!reset || m_idle) begin
      es = 0; e_req = 0; e_pc = 0; e_fl = 1; e_bub = 1;
    end else if (m_flush_left > 0) begin
      es = 3; e_req = 1; e_pc = 0; e_fl = 1; e_bub = 1; we_known = 0;
    end else begin
      es = m_wait ? 2 : 1; e_req = 1;
      if (branch_taken) begin
        e_pc = 1; e_fl = 1; e_bub = 1; we_known = 0;
      end else if (m_hazard()) begin
        e_pc = 0; e_fl = 0; e_bub = 1; e_we = 0;
      end else if (!imem_ready) begin
        e_pc = 0; e_fl = 1; e_bub = 0; we_known = 0;
      end else begin
        e_pc = 1; e_fl = 0; e_bub = 0; e_we = 1;
      end
    end
    check("state", 32'(state), 32'(es));
    check("imem_req", 32'(imem_req), 32'(e_req));
    check("pc_we", 32'(pc_we), 32'(e_pc));
    check("if_id_flush", 32'(if_id_flush), 32'(e_fl));
    check("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
    if (we_known) check("if_id_we", 32'(if_id_we), 32'(e_we));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
`else
    check("stall_cnt", 32'(stall_cnt), 32'd0);
    check("flush_cnt", 32'(flush_cnt), 32'd0);
`endif
  endtask

  // One cycle: drive at negedge, check mid-low-phase, advance model at posedge.
  task automatic tick(input bit rst_n, input bit mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                      input bit br, input bit rdy);
    reset = rst_n; ex_mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    id_uses_rt = urt; branch_taken = br; imem_ready = rdy;
    #2;
    if (!reset) model_reset();
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 0; ex_mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
    id_uses_rt = 0; branch_taken = 0; imem_ready = 1;
    model_reset();
    @(negedge clk);

    // Reset release: two cycles low, then IDLE then RUN.
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 0, 1);
    check("rel_cyc2_state", 32'(state), 32'd1);
    check("rel_cyc2_req", 32'(imem_req), 32'd1);
    idle_cyc(1);

    // Load-use stall on rs, then released.
    tick(1, 1, 8, 8, 0, 0, 0, 1);
    tick(1, 0, 8, 8, 0, 0, 0, 1);
    // Zero register and rt gating.
    tick(1, 1, 0, 0, 0, 1, 0, 1);
    tick(1, 1, 9, 1, 9, 0, 0, 1);
    tick(1, 1, 9, 1, 9, 1, 0, 1);

    // Branch: resolve cycle plus two FLUSH cycles, back to RUN.
    tick(1, 0, 0, 0, 0, 0, 1, 1);
    check("br_flush_state", 32'(state), 32'd3);
    idle_cyc(2);
    check("br_back_run", 32'(state), 32'd1);
    idle_cyc(1);

    // Fetch latency.
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0, 0, 0, 0);
    check("wait_state", 32'(state), 32'd2);
    idle_cyc(2);

    // Reset during FLUSH.
    tick(1, 0, 0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    idle_cyc(3);

    // Branch and hazard together.
    tick(1, 1, 5, 5, 0, 0, 1, 1);
    idle_cyc(3);
    // Hazard while waiting on fetch.
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 4, 0, 4, 1, 0, 0);
    idle_cyc(2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit r, mr, urt, br, rdy;
      r   = ($urandom_range(99) >= 2);
      mr  = ($urandom_range(99) < 45);
      urt = $urandom_range(1);
      br  = ($urandom_range(99) < 10);
      rdy = ($urandom_range(99) < 75);
      tick(r, mr, 5'($urandom_range(3)), 5'($urandom_range(3)),
           5'($urandom_range(3)), urt, br, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core's front end. Generates PC write enable, IF_ID write/flush and ID_EX bubble controls from three conditions:
- load-use hazards in ID;
- taken branches resolved in EX;
- instruction-memory fetch latency.

Sits beside IF_ID and the PC register; all stall/flush decisions for IF and ID originate here.

## Interface
Parameters:
- FLUSH_SLOTS, 1: wrong-path cycles flushed per taken branch (legal 1..7).
- CNT_W, 16: width of performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of instruction in ID (IF_ID instr_out[25:21]).
- id_rt  in  5  rt field of instruction in ID (instr_out[20:16]).
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- branch_taken  in  1  branch in EX resolved taken this cycle.
- imem_ready  in  1  instruction memory returns a valid word this cycle.
- imem_req  out  1  fetch request to instruction memory.
- pc_we  out  1  PC register load enable.
- if_id_we  out  1  IF_ID load enable.
- if_id_flush  out  1  IF_ID loads 32'h0 (NOP); overrides if_id_we.
- id_ex_bubble  out  1  ID_EX loads all-zero control (bubble).
- state  out  2  current FSM state.
- stall_cnt  out  CNT_W  load-use stall cycle count.
- flush_cnt  out  CNT_W  branch flush count.

## Operation
FSM states: IDLE=0, RUN=1, WAIT=2, FLUSH=3.

Definition:
- hazard = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).

Outputs are combinational from state and inputs.

IDLE:
- Outputs: imem_req=0, pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1.
- Always -> RUN next cycle.

RUN and WAIT: imem_req=1. Priority, first match wins:
1. branch_taken:
   - pc_we=1, if_id_flush=1, id_ex_bubble=1.
   - -> FLUSH if FLUSH_SLOTS>1 (slot counter loaded with FLUSH_SLOTS-1); else -> RUN.
   - An outstanding fetch in WAIT is abandoned.
2. hazard:
   - pc_we=0, if_id_we=0, if_id_flush=0, id_ex_bubble=1.
   - Stay in current state.
3. !imem_ready:
   - pc_we=0, if_id_flush=1 (NOP into IF_ID), id_ex_bubble=0.
   - -> WAIT.
4. Otherwise:
   - pc_we=1, if_id_we=1, if_id_flush=0, id_ex_bubble=0.
   - -> RUN.

FLUSH:
- Outputs: imem_req=1, pc_we=0, if_id_flush=1, id_ex_bubble=1.
- Slot counter decrements each cycle; -> RUN when it reaches 0 while in FLUSH.
- branch_taken and hazard are ignored (EX holds a bubble).

Rules:
- Register 0 never creates a hazard (ex_rt==0 is excluded).
- Simultaneous branch_taken and hazard: branch wins; the stalled instruction is wrong-path and is flushed.

## Timing
- Reset asserted (any time, including mid-stall or mid-flush): state=IDLE, slot counter=0, counters=0, outputs take IDLE values immediately.
- First fetch (imem_req=1) occurs in the 2nd cycle after reset deasserts.
- Load-use stall lasts exactly 1 cycle: next cycle the load is in MEM, so the hazard clears.
- Taken branch costs FLUSH_SLOTS cycles of IF_ID NOPs, counting the resolve cycle.
- WAIT persists for any number of cycles until imem_ready=1; the PC is held throughout.
- All state updates occur on the rising clk edge.

## Configuration
Macro: PIPE_HAZARD_CTRL_PERF_EN.

Defined:
- stall_cnt increments on every cycle the hazard rule fires.
- flush_cnt increments on every branch_taken accepted in RUN/WAIT.
- Both counters saturate at all-ones and clear on reset.

Undefined:
- Counter logic is not compiled in; stall_cnt and flush_cnt are tied to 0.
- All other behaviour is identical.

## Test plan
- Reset release: reset low for 2 cycles, then high -> during reset state=0, if_id_flush=1, pc_we=0. Cycle 1 after release: state=0. Cycle 2: state=1, imem_req=1.
- Load-use stall: RUN, imem_ready=1, ex_mem_read=1, ex_rt=8, id_rs=8 -> pc_we=0, if_id_we=0, id_ex_bubble=1 for one cycle. Clearing ex_mem_read restores pc_we=1. stall_cnt=1 with macro defined.
- Zero register and rt gating, each -> no stall, pc_we=1:
  - ex_rt=0, id_rs=0;
  - ex_rt=9, id_rt=9, id_uses_rt=0.
- Branch with FLUSH_SLOTS=3: branch_taken pulse in RUN -> pc_we=1 and if_id_flush=1 that cycle. state=3 for the next 2 cycles with pc_we=0. Then state=1. flush_cnt=1.
- Fetch latency: imem_ready low for 3 cycles -> state=2, pc_we=0, if_id_flush=1 each cycle. imem_ready=1 -> pc_we=1, if_id_we=1, state returns to 1.
- Reset mid-FLUSH and branch+hazard collision:
  - reset asserted in FLUSH -> state=0 immediately, no further flush cycles after release.
  - branch_taken and hazard together -> flush path taken, id_ex_bubble=1, stall_cnt unchanged.
